aes_cipher_arbiter: RTL and testbench

Shares one AES cipher core between NUM_REQ independent requesters, for example a CPU register interface and a DMA/key-derivation engine. It arbitrates requests round-robin and latches the winner's op, key length and dec-key-gen mode. It then sequences the core's start/input handshake and routes the core's output handshake back to the granted requester only. Exactly one operation is in flight at a time, and a watchdog flags a core that never completes.

---
 rtl/aes_cipher_arbiter.sv | 173 +++++++++++++++++
 tb/tb_aes_cipher_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_arbiter.sv
// Round-robin arbiter sharing one AES cipher core between NUM_REQ requesters.
// One operation in flight; the winner's op/key_len/dec_key_gen are latched for its whole duration.
module aes_cipher_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [NUM_REQ-1:0]     req_op_i,
   input  logic [3*NUM_REQ-1:0]   req_key_len_i,
   input  logic [NUM_REQ-1:0]     req_dec_key_gen_i,
   output logic [NUM_REQ-1:0]     rsp_valid_o,
   input  logic [NUM_REQ-1:0]     rsp_ready_i,
   output logic                   ciph_in_valid_o,
   input  logic                   ciph_in_ready_i,
   output logic                   ciph_start_o,
   output logic                   ciph_op_o,
   output logic [2:0]             ciph_key_len_o,
   output logic                   ciph_dec_key_gen_o,
   input  logic                   ciph_out_valid_i,
   output logic                   ciph_out_ready_o,
   output logic [NUM_REQ-1:0]     grant_o,
   output logic                   busy_o,
   output logic                   err_timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYCLES);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 op_q, op_d;
   logic [2:0]           key_len_q, key_len_d;
   logic                 dkg_q, dkg_d;
   logic [15:0]          timer_q, timer_d;
   logic                 err_q, err_d;

   logic [2:0]           key_len_arr [NUM_REQ];
   logic                 pick_vld;
   logic [IDX_W-1:0]     pick_idx;
   int                   cand;
   int                   nxt_ptr;
   logic                 out_hs;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_kl
      assign key_len_arr[g] = req_key_len_i[3*g +: 3];
   end

   // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!pick_vld && req_valid_i[IDX_W'(cand)]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      gidx_d           = gidx_q;
      grant_d          = grant_q;
      op_d             = op_q;
      key_len_d        = key_len_q;
      dkg_d            = dkg_q;
      timer_d          = timer_q;
      err_d            = err_q;
      nxt_ptr          = 0;
      out_hs           = 1'b0;
      req_ready_o      = '0;
      rsp_valid_o      = '0;
      ciph_in_valid_o  = 1'b0;
      ciph_start_o     = 1'b0;
      ciph_out_ready_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d   = ST_ISSUE;
               gidx_d    = pick_idx;
               grant_d   = NUM_REQ'(1) << pick_idx;
               op_d      = req_op_i[pick_idx];
               key_len_d = key_len_arr[pick_idx];
               dkg_d     = req_dec_key_gen_i[pick_idx];
            end
         end
         ST_ISSUE: begin
            ciph_in_valid_o = 1'b1;
            ciph_start_o    = 1'b1;
            if (ciph_in_ready_i) begin
               req_ready_o = grant_q;
               state_d     = ST_WAIT;
               timer_d     = '0;
            end
         end
         ST_WAIT: begin
            ciph_out_ready_o = |(rsp_ready_i & grant_q);
            if (ciph_out_valid_i) rsp_valid_o = grant_q;
            out_hs = ciph_out_valid_i && (|(rsp_ready_i & grant_q));
            if (out_hs) begin
               state_d = ST_IDLE;
               grant_d = '0;
               nxt_ptr = int'(gidx_q) + 1;
               if (nxt_ptr >= NUM_REQ) nxt_ptr = 0;
               rr_ptr_d = IDX_W'(nxt_ptr);
            end else begin
               // Watchdog only flags; the operation keeps waiting for the core.
               if (timer_q == TO_LAST) err_d = 1'b1;
               if (timer_q != TO_MAX) timer_d = timer_q + 16'd1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rr_ptr_d  = '0;
            gidx_d    = '0;
            grant_d   = '0;
            op_d      = 1'b0;
            key_len_d = '0;
            dkg_d     = 1'b0;
            timer_d   = '0;
            err_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         gidx_q    <= '0;
         grant_q   <= '0;
         op_q      <= 1'b0;
         key_len_q <= '0;
         dkg_q     <= 1'b0;
         timer_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gidx_q    <= gidx_d;
         grant_q   <= grant_d;
         op_q      <= op_d;
         key_len_q <= key_len_d;
         dkg_q     <= dkg_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
      end
   end

   assign ciph_op_o          = op_q;
   assign ciph_key_len_o     = key_len_q;
   assign ciph_dec_key_gen_o = dkg_q;
   assign grant_o            = grant_q;
   assign busy_o             = (state_q != ST_IDLE);
   assign err_timeout_o      = err_q;

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// Bench for aes_cipher_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_aes_cipher_arbiter;
   localparam int N = 3;
   localparam int T = 16;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid, req_op, req_dkg, rsp_ready;
   logic [3*N-1:0] req_kl;
   logic           in_ready, out_valid;
   logic [N-1:0]   req_ready, rsp_valid, grant;
   logic           in_valid, start, c_op, c_dkg, out_ready, busy, err;
   logic [2:0]     c_kl;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int       m_owner;
   bit       m_in_wait;
   int       m_ptr, m_timer;
   bit       m_err, m_op, m_dkg;
   bit [2:0] m_kl;

   aes_cipher_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_key_len_i(req_kl), .req_dec_key_gen_i(req_dkg),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .ciph_in_valid_o(in_valid), .ciph_in_ready_i(in_ready), .ciph_start_o(start),
      .ciph_op_o(c_op), .ciph_key_len_o(c_kl), .ciph_dec_key_gen_o(c_dkg),
      .ciph_out_valid_i(out_valid), .ciph_out_ready_o(out_ready),
      .grant_o(grant), .busy_o(busy), .err_timeout_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_op = '0; req_dkg = '0; rsp_ready = '0;
      req_kl = '0; in_ready = 1'b0; out_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic model_reset();
      m_owner = -1; m_in_wait = 0; m_ptr = 0; m_timer = 0;
      m_err = 0; m_op = 0; m_kl = '0; m_dkg = 0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (m_owner < 0 && ((req_valid >> c) & 3'b001) != 0) begin
               m_owner   = c;
               m_op      = 1'((req_op >> c));
               m_dkg     = 1'((req_dkg >> c));
               m_kl      = 3'((req_kl >> (3*c)));
               m_in_wait = 0;
            end
         end
      end else if (!m_in_wait) begin
         if (in_ready) begin
            m_in_wait = 1;
            m_timer   = 0;
         end
      end else begin
         if (out_valid && ((rsp_ready >> m_owner) & 3'b001) != 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_in_wait = 0;
         end else begin
            if (m_timer == T - 1) m_err = 1;
            if (m_timer < T) m_timer++;
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({busy, grant, err, in_valid, start, out_ready, req_ready, rsp_valid, c_op, c_kl, c_dkg} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b grant=%b err=%b in_valid=%b req_ready=%b rsp_valid=%b op=%b kl=%b, want all 0",
                  busy, grant, err, in_valid, req_ready, rsp_valid, c_op, c_kl);
      end
      rst = 1'b0;
      req_valid = 3'b111; in_ready = 1'b1; out_valid = 1'b1; rsp_ready = 3'b111;
      tick();
      n_vec++;
      if (grant !== 3'b001) begin
         n_err++;
         $display("FAIL reset_first_grant: got %b want 001", grant);
      end
      req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 3'b001; req_op = 3'b000; req_kl = 9'b000_000_001;
      in_ready = 1'b1; rsp_ready = 3'b001;
      #1;
      n_vec++;
      if ({in_valid, req_ready, busy} !== 5'b0) begin
         n_err++;
         $display("FAIL single_idle: got in_valid=%b req_ready=%b busy=%b want 0", in_valid, req_ready, busy);
      end
      tick();
      n_vec++;
      if ({in_valid, start, req_ready, grant, busy, c_op, c_kl} !== {1'b1, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 3'b001}) begin
         n_err++;
         $display("FAIL single_issue: got in_valid=%b start=%b req_ready=%b grant=%b busy=%b op=%b kl=%b",
                  in_valid, start, req_ready, grant, busy, c_op, c_kl);
      end
      tick();
      req_valid = '0;
      #1;
      n_vec++;
      if ({in_valid, start, req_ready, busy} !== {1'b0, 1'b0, 3'b000, 1'b1}) begin
         n_err++;
         $display("FAIL single_wait: got in_valid=%b start=%b req_ready=%b busy=%b", in_valid, start, req_ready, busy);
      end
      for (int k = 0; k < 11; k++) begin
         tick();
         n_vec++;
         if ({rsp_valid, busy} !== {3'b000, 1'b1}) begin
            n_err++;
            $display("FAIL single_pending: cycle %0d got rsp_valid=%b busy=%b want 000/1", k, rsp_valid, busy);
         end
      end
      out_valid = 1'b1;
      #1;
      n_vec++;
      if ({rsp_valid, out_ready} !== {3'b001, 1'b1}) begin
         n_err++;
         $display("FAIL single_rsp: got rsp_valid=%b out_ready=%b want 001/1", rsp_valid, out_ready);
      end
      tick();
      out_valid = 1'b0;
      #1;
      n_vec++;
      if ({busy, grant, rsp_valid} !== 7'b0) begin
         n_err++;
         $display("FAIL single_done: got busy=%b grant=%b rsp_valid=%b want 0", busy, grant, rsp_valid);
      end
   endtask

   task automatic test_fairness();
      bit [2:0] exp_g [4];
      exp_g = '{3'b001, 3'b010, 3'b001, 3'b010};
      do_reset();
      req_valid = 3'b011; req_dkg = 3'b010; in_ready = 1'b1; out_valid = 1'b1; rsp_ready = 3'b111;
      for (int op = 0; op < 4; op++) begin
         int guard;
         guard = 0;
         while (!in_valid && guard < 20) begin
            tick();
            guard++;
         end
         n_vec++;
         if ({in_valid, grant, c_dkg} !== {1'b1, exp_g[op], exp_g[op][1]}) begin
            n_err++;
            $display("FAIL fairness_grant%0d: got in_valid=%b grant=%b dkg=%b want 1/%b/%b",
                     op, in_valid, grant, c_dkg, exp_g[op], exp_g[op][1]);
         end
         tick();
      end
      req_valid = '0;
      tick();
      tick();
   endtask

   task automatic test_stability();
      do_reset();
      req_valid = 3'b010; req_op = 3'b010; req_kl = {3'b001, 3'b100, 3'b001};
      in_ready = 1'b1;
      tick();
      n_vec++;
      if ({grant, c_op, c_kl} !== {3'b010, 1'b1, 3'b100}) begin
         n_err++;
         $display("FAIL stab_latch: got grant=%b op=%b kl=%b want 010/1/100", grant, c_op, c_kl);
      end
      req_valid = 3'b101; req_op = 3'b101; req_kl = {3{3'b010}};
      for (int k = 0; k < 6; k++) begin
         tick();
         n_vec++;
         if ({busy, grant, c_op, c_kl} !== {1'b1, 3'b010, 1'b1, 3'b100}) begin
            n_err++;
            $display("FAIL stab_hold%0d: got busy=%b grant=%b op=%b kl=%b want 1/010/1/100", k, busy, grant, c_op, c_kl);
         end
      end
      req_valid = '0; out_valid = 1'b1; rsp_ready = 3'b010;
      tick();
      out_valid = 1'b0;
      #1;
      n_vec++;
      if ({busy, c_op, c_kl} !== {1'b0, 1'b1, 3'b100}) begin
         n_err++;
         $display("FAIL stab_idle: got busy=%b op=%b kl=%b want 0/1/100", busy, c_op, c_kl);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 3'b001; in_ready = 1'b0;
      tick();
      req_valid = 3'b111;
      #1;
      for (int k = 0; k < 5; k++) begin
         n_vec++;
         if ({start, in_valid, req_ready, busy} !== {1'b1, 1'b1, 3'b000, 1'b1}) begin
            n_err++;
            $display("FAIL bp_issue%0d: got start=%b in_valid=%b req_ready=%b busy=%b", k, start, in_valid, req_ready, busy);
         end
         tick();
      end
      in_ready = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== 3'b001) begin
         n_err++;
         $display("FAIL bp_accept: got req_ready=%b want 001", req_ready);
      end
      tick();
      in_ready = 1'b0; req_valid = '0; out_valid = 1'b1; rsp_ready = 3'b110;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if ({out_ready, rsp_valid, busy, grant} !== {1'b0, 3'b001, 1'b1, 3'b001}) begin
            n_err++;
            $display("FAIL bp_rsp%0d: got out_ready=%b rsp_valid=%b busy=%b grant=%b", k, out_ready, rsp_valid, busy, grant);
         end
         tick();
      end
      rsp_ready = 3'b001;
      #1;
      n_vec++;
      if (out_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_out_ready: got %b want 1", out_ready);
      end
      tick();
      out_valid = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_done: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      req_valid = 3'b001; in_ready = 1'b1; rsp_ready = 3'b001;
      tick();
      req_valid = '0;
      tick();
      for (int k = 0; k < T; k++) begin
         n_vec++;
         if (err !== 1'b0) begin
            n_err++;
            $display("FAIL wd_early: wait cycle %0d got err=%b want 0", k, err);
         end
         tick();
      end
      n_vec++;
      if ({err, busy} !== 2'b11) begin
         n_err++;
         $display("FAIL wd_set: got err=%b busy=%b want 1/1", err, busy);
      end
      repeat (5) tick();
      n_vec++;
      if (err !== 1'b1) begin
         n_err++;
         $display("FAIL wd_sticky: got err=%b want 1", err);
      end
      out_valid = 1'b1;
      #1;
      n_vec++;
      if (rsp_valid !== 3'b001) begin
         n_err++;
         $display("FAIL wd_late_rsp: got rsp_valid=%b want 001", rsp_valid);
      end
      tick();
      out_valid = 1'b0;
      #1;
      n_vec++;
      if ({busy, err} !== 2'b01) begin
         n_err++;
         $display("FAIL wd_done: got busy=%b err=%b want 0/1", busy, err);
      end
   endtask

   task automatic test_reset_mid();
      req_valid = 3'b010; in_ready = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({busy, grant, err} !== {1'b1, 3'b010, 1'b1}) begin
         n_err++;
         $display("FAIL rstmid_pre: got busy=%b grant=%b err=%b want 1/010/1", busy, grant, err);
      end
      rst = 1'b1; req_valid = 3'b011;
      tick();
      n_vec++;
      if ({busy, grant, err, in_valid, out_ready, c_op, c_kl} !== '0) begin
         n_err++;
         $display("FAIL rstmid_state: got busy=%b grant=%b err=%b in_valid=%b out_ready=%b kl=%b want 0",
                  busy, grant, err, in_valid, out_ready, c_kl);
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if (grant !== 3'b001) begin
         n_err++;
         $display("FAIL rstmid_ptr: got grant=%b want 001", grant);
      end
      out_valid = 1'b1; rsp_ready = 3'b111;
      tick();
      tick();
      tick();
      n_vec++;
      if ({grant, in_valid} !== {3'b010, 1'b1}) begin
         n_err++;
         $display("FAIL rstmid_pending: got grant=%b in_valid=%b want 010/1", grant, in_valid);
      end
      req_valid = '0;
      tick();
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      int ov_pct;
      bit [N-1:0] e_grant, e_req_ready, e_rsp_valid;
      bit e_issue, e_wait, e_out_ready;
      do_reset();
      model_reset();
      ov_pct = 30;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 250 == 0) begin
            case ($urandom_range(0, 3))
               0: ov_pct = 0;
               1: ov_pct = 5;
               2: ov_pct = 30;
               default: ov_pct = 80;
            endcase
         end
         rst       = ($urandom_range(0, 299) == 0);
         req_valid = N'($urandom);
         req_op    = N'($urandom);
         req_dkg   = N'($urandom);
         req_kl    = (3*N)'($urandom);
         rsp_ready = N'($urandom);
         in_ready  = ($urandom_range(0, 99) < 60);
         out_valid = ($urandom_range(0, 99) < ov_pct);
         #1;
         e_grant     = (m_owner < 0) ? '0 : N'(1 << m_owner);
         e_issue     = (m_owner >= 0) && !m_in_wait;
         e_wait      = (m_owner >= 0) && m_in_wait;
         e_req_ready = (e_issue && in_ready) ? e_grant : '0;
         e_rsp_valid = (e_wait && out_valid) ? e_grant : '0;
         e_out_ready = e_wait && ((rsp_ready & e_grant) != 0);
         n_vec++;
         if ({in_valid, start, req_ready, rsp_valid, out_ready} !==
             {e_issue, e_issue, e_req_ready, e_rsp_valid, e_out_ready}) begin
            n_err++;
            $display("FAIL rand_hs cyc %0d: got in_v=%b start=%b req_rdy=%b rsp_v=%b out_rdy=%b want %b %b %b %b %b",
                     cyc, in_valid, start, req_ready, rsp_valid, out_ready,
                     e_issue, e_issue, e_req_ready, e_rsp_valid, e_out_ready);
         end
         n_vec++;
         if ({grant, busy, err, c_op, c_kl, c_dkg} !== {e_grant, (m_owner >= 0), m_err, m_op, m_kl, m_dkg}) begin
            n_err++;
            $display("FAIL rand_reg cyc %0d: got grant=%b busy=%b err=%b op=%b kl=%b dkg=%b want %b %b %b %b %b %b",
                     cyc, grant, busy, err, c_op, c_kl, c_dkg,
                     e_grant, (m_owner >= 0), m_err, m_op, m_kl, m_dkg);
         end
         model_step();
         tick();
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_fairness();
      test_stability();
      test_backpressure();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
